// File: rtl/streaming_hash_core_if.sv
// Word-in / digest-out handshake bundle for streaming_hash_core.
// The master side feeds message words and takes digests; the slave side is the core.
interface streaming_hash_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned HASH_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [HASH_W-1:0] hash_out;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, hash_out, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, hash_out, out_valid
    );
endinterface

// File: rtl/streaming_hash_core.sv
// Streaming hash: absorbs framed DATA_W-bit words into rotating lanes of a HASH_W state,
// applies a length-finalisation round, then holds the digest until the consumer takes it.
module streaming_hash_core #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       HASH_W = 32,
    parameter logic [HASH_W-1:0] SEED   = 32'h4242_4242,
    parameter int unsigned       LEN_W  = 16
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 clear,
    streaming_hash_core_if.slave bus
);
    localparam int unsigned LANES  = HASH_W / DATA_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_ABSORB,
        S_FINAL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [HASH_W-1:0]  h_q, h_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    // Rotating left by half the width is just a swap of the two halves.
    function automatic logic [HASH_W-1:0] mix(input logic [HASH_W-1:0] m);
        return m ^ {m[HASH_W/2-1:0], m[HASH_W-1:HASH_W/2]};
    endfunction

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_ABSORB: begin
                if (bus.in_valid) begin
                    h_d    = mix(h_q ^ (HASH_W'(bus.in_data) << (int'(lane_q) * DATA_W)));
                    lane_d = (lane_q == LANE_W'(LANES - 1)) ? '0 : lane_q + LANE_W'(1);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (bus.in_last) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                h_d     = mix(h_q ^ HASH_W'(cnt_q));
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    h_d     = SEED;
                    lane_d  = '0;
                    cnt_d   = '0;
                    state_d = S_ABSORB;
                end
            end
            default: begin
                state_d = S_ABSORB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= S_ABSORB;
            h_q     <= SEED;
            lane_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ABSORB);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.hash_out  = h_q;
endmodule

// File: tb/tb_streaming_hash_core.sv
// Drives one shared message stream into three core configurations and checks each
// against an arithmetic reference model of the hash rules.
module tb_streaming_hash_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] d   = '0;
    logic       v   = 1'b0;
    logic       l   = 1'b0;
    logic       ordy = 1'b0;

    int nchk  = 0;
    int nfail = 0;

    // Config 0: 8/8 seed 42 len 8; config 1: defaults; config 2: 32-bit hash, 2-bit counter.
    int          hw [3] = '{8, 32, 32};
    int          lw [3] = '{8, 16, 2};
    logic [31:0] sd [3] = '{32'h42, 32'h4242_4242, 32'h4242_4242};
    logic [31:0] exp_dig [3];

    always #5 clk = ~clk;

    streaming_hash_core_if #(.DATA_W(8), .HASH_W(8))  b8 ();
    streaming_hash_core_if #(.DATA_W(8), .HASH_W(32)) b32 ();
    streaming_hash_core_if #(.DATA_W(8), .HASH_W(32)) bw ();

    assign b8.in_data   = d;  assign b32.in_data   = d;  assign bw.in_data   = d;
    assign b8.in_valid  = v;  assign b32.in_valid  = v;  assign bw.in_valid  = v;
    assign b8.in_last   = l;  assign b32.in_last   = l;  assign bw.in_last   = l;
    assign b8.out_ready = ordy; assign b32.out_ready = ordy; assign bw.out_ready = ordy;

    streaming_hash_core #(.DATA_W(8), .HASH_W(8), .SEED(8'h42), .LEN_W(8)) u8 (
        .clk(clk), .rst(rst), .clear(clr), .bus(b8));
    streaming_hash_core #(.DATA_W(8), .HASH_W(32), .SEED(32'h4242_4242), .LEN_W(16)) u32 (
        .clk(clk), .rst(rst), .clear(clr), .bus(b32));
    streaming_hash_core #(.DATA_W(8), .HASH_W(32), .SEED(32'h4242_4242), .LEN_W(2)) uw (
        .clk(clk), .rst(rst), .clear(clr), .bus(bw));

    function automatic logic [31:0] hv(int k);
        case (k)
            0:       return {24'b0, b8.hash_out};
            1:       return b32.hash_out;
            default: return bw.hash_out;
        endcase
    endfunction

    function automatic logic ov(int k);
        case (k)
            0:       return b8.out_valid;
            1:       return b32.out_valid;
            default: return bw.out_valid;
        endcase
    endfunction

    function automatic logic ir(int k);
        case (k)
            0:       return b8.in_ready;
            1:       return b32.in_ready;
            default: return bw.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] mix(logic [31:0] x, int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = x & m;
        return x ^ (((x << (w / 2)) | (x >> (w / 2))) & m);
    endfunction

    // State after absorbing the first n words, optionally followed by the length round.
    function automatic logic [31:0] model(int k, logic [7:0] w[$], int n, bit fin);
        logic [31:0] h;
        h = sd[k];
        for (int i = 0; i < n; i++)
            h = mix(h ^ (32'(w[i]) << (8 * (i % (hw[k] / 8)))), hw[k]);
        if (fin)
            h = mix(h ^ (32'(n) % (32'd1 << lw[k])), hw[k]);
        return h;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic absorb_msg(logic [7:0] w[$], int gmax);
        for (int i = 0; i < w.size(); i++) begin
            int g = $urandom_range(gmax);
            for (int j = 0; j < g; j++) begin
                v = 1'b0; l = 1'($urandom); d = 8'($urandom);
                step();
            end
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (ir(k) !== 1'b1) begin
                    nfail++; $display("FAIL ready_absorb[%0d]: got %b expected 1", k, ir(k));
                end
            end
            d = w[i]; v = 1'b1; l = (i == w.size() - 1);
            step();
            v = 1'b0; l = 1'b0;
            for (int k = 0; k < 3; k++) begin
                logic [31:0] e = model(k, w, i + 1, 1'b0);
                nchk++;
                if (hv(k) !== e) begin
                    nfail++; $display("FAIL absorb_h[%0d] word %0d: got %h expected %h", k, i, hv(k), e);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (ov(k) !== 1'b0 || ir(k) !== 1'b0) begin
                nfail++; $display("FAIL final_cycle[%0d]: got valid %b ready %b expected 0 0", k, ov(k), ir(k));
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            exp_dig[k] = model(k, w, w.size(), 1'b1);
            nchk++;
            if (ov(k) !== 1'b1 || hv(k) !== exp_dig[k]) begin
                nfail++; $display("FAIL digest[%0d]: got valid %b hash %h expected 1 %h", k, ov(k), hv(k), exp_dig[k]);
            end
        end
    endtask

    task automatic handoff(int bp);
        ordy = 1'b0;
        for (int j = 0; j < bp; j++) begin
            d = 8'($urandom); v = 1'($urandom); l = 1'($urandom);
            step();
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (ov(k) !== 1'b1 || ir(k) !== 1'b0 || hv(k) !== exp_dig[k]) begin
                    nfail++;
                    $display("FAIL hold[%0d]: got valid %b ready %b hash %h expected 1 0 %h", k, ov(k), ir(k), hv(k), exp_dig[k]);
                end
            end
        end
        v = 1'b0; l = 1'b0; ordy = 1'b1;
        step();
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (ir(k) !== 1'b1 || ov(k) !== 1'b0 || hv(k) !== sd[k]) begin
                nfail++;
                $display("FAIL turnaround[%0d]: got ready %b valid %b hash %h expected 1 0 %h", k, ir(k), ov(k), hv(k), sd[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (ir(k) !== 1'b1 || ov(k) !== 1'b0 || hv(k) !== sd[k]) begin
                nfail++;
                $display("FAIL reset[%0d]: got ready %b valid %b hash %h expected 1 0 %h", k, ir(k), ov(k), hv(k), sd[k]);
            end
        end
    endtask

    task automatic test_vectors();
        absorb_msg('{8'h00}, 0);
        nchk++;
        if (b8.hash_out !== 8'h11) begin
            nfail++; $display("FAIL vec_00: got %h expected 11", b8.hash_out);
        end
        handoff(0);
        absorb_msg('{8'h01, 8'h02}, 0);
        nchk++;
        if (b8.hash_out !== 8'h22) begin
            nfail++; $display("FAIL vec_0102: got %h expected 22", b8.hash_out);
        end
        handoff(1);
        absorb_msg('{8'hAA}, 0);
        nchk++;
        if (b32.hash_out !== 32'h0001_0001) begin
            nfail++; $display("FAIL vec_AA: got %h expected 00010001", b32.hash_out);
        end
        handoff(5);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom); v = 1'b1; l = 1'b0;
            step();
        end
        clr = 1'b1; d = 8'($urandom); v = 1'b1; l = 1'($urandom);
        step();
        clr = 1'b0; v = 1'b0; l = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (hv(k) !== sd[k] || ir(k) !== 1'b1 || ov(k) !== 1'b0) begin
                nfail++; $display("FAIL clear[%0d]: got hash %h ready %b expected %h 1", k, hv(k), ir(k), sd[k]);
            end
        end
        absorb_msg('{8'h00}, 1);
        nchk++;
        if (b8.hash_out !== 8'h11) begin
            nfail++; $display("FAIL clear_then_00: got %h expected 11", b8.hash_out);
        end
        handoff(2);
    endtask

    task automatic test_reset_done();
        logic [7:0] w[$];
        for (int i = 0; i < 4; i++) w.push_back(8'($urandom));
        absorb_msg(w, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (ov(k) !== 1'b0 || hv(k) !== sd[k] || ir(k) !== 1'b1) begin
                nfail++; $display("FAIL reset_done[%0d]: got valid %b hash %h expected 0 %h", k, ov(k), hv(k), sd[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] w[$];
        for (int i = 0; i < 5; i++) w.push_back(8'($urandom));
        absorb_msg(w, 0);
        handoff(1);
    endtask

    task automatic test_random();
        for (int m = 0; m < 25; m++) begin
            logic [7:0] w[$];
            int n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) w.push_back(8'($urandom));
            absorb_msg(w, 2);
            handoff($urandom_range(3));
        end
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 4; m++) begin
            logic [7:0] w[$];
            int n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) w.push_back(8'($urandom));
            absorb_msg(w, 0);
            handoff(0);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_clear();
        test_reset_done();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
